reg_writeback_unit: RTL

- Write-side driver of the RV32I register file write port (we, rd address, rd data).
- Merges two result sources, ALU results and load responses from data memory, onto the single write port.
- Tracks one outstanding load with an FSM and formats load data (byte/half extraction, sign/zero extension).
- Exports load-pending status to the hazard logic.

---
 rtl/reg_writeback_unit_pkg.sv | 22 ++
 rtl/reg_writeback_unit_if.sv | 44 ++++
 rtl/reg_writeback_unit_load_formatter.sv | 54 +++++
 rtl/reg_writeback_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// Shared configuration for the register write-back slice: data/register
// sizing, RV32I load funct3 encodings and the load-tracking FSM states.
package reg_writeback_unit_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REGISTER = 32;
  localparam int REG_AW       = $clog2(NUM_REGISTER);

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle of the ALU result channel, load issue/response channel, the
// register-file write port and the hazard status outputs.
interface reg_writeback_unit_if
  import reg_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH = reg_writeback_unit_pkg::DATA_WIDTH,
  parameter int AW         = reg_writeback_unit_pkg::REG_AW
);
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [AW-1:0]         alu_rd_addr_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  ld_issue_i;
  logic                  ld_ready_o;
  logic [AW-1:0]         ld_rd_addr_i;
  logic [2:0]            ld_funct3_i;
  logic [1:0]            ld_offset_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  we_o;
  logic [AW-1:0]         rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_o;
  logic                  load_busy_o;
  logic [AW-1:0]         load_rd_o;
  logic                  load_err_o;

  // Write-back unit side
  modport slave (
    input  alu_valid_i, alu_rd_addr_i, alu_data_i,
    input  ld_issue_i, ld_rd_addr_i, ld_funct3_i, ld_offset_i,
    input  mem_rvalid_i, mem_rdata_i,
    output alu_ready_o, ld_ready_o, we_o, rd_addr_o, rd_o,
    output load_busy_o, load_rd_o, load_err_o
  );

  // Pipeline / memory side
  modport master (
    output alu_valid_i, alu_rd_addr_i, alu_data_i,
    output ld_issue_i, ld_rd_addr_i, ld_funct3_i, ld_offset_i,
    output mem_rvalid_i, mem_rdata_i,
    input  alu_ready_o, ld_ready_o, we_o, rd_addr_o, rd_o,
    input  load_busy_o, load_rd_o, load_err_o
  );
endinterface

// File: rtl/reg_writeback_unit_load_formatter.sv
// Combinational load data formatter: picks the byte/half selected by the
// address offset, extends it per funct3 and flags misaligned or illegal loads.
module load_formatter
  import reg_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH = reg_writeback_unit_pkg::DATA_WIDTH
) (
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_offset,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_misaligned,
  output logic                  o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

  function automatic logic [DATA_WIDTH-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(DATA_WIDTH-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(DATA_WIDTH-16){sgn & h[15]}}, h};
  endfunction

  // Decode funct3 into formatted data and alignment/legality flags
  always_comb begin
    o_data       = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      LB:  o_data = ext_byte(w_byte, 1'b1);
      LBU: o_data = ext_byte(w_byte, 1'b0);
      LH: begin
        o_data       = ext_half(w_half, 1'b1);
        o_misaligned = i_offset[0];
      end
      LHU: begin
        o_data       = ext_half(w_half, 1'b0);
        o_misaligned = i_offset[0];
      end
      LW: begin
        o_data       = i_rdata;
        o_misaligned = |i_offset;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-back driver: merges ALU results and load responses onto
// one write port, tracks a single outstanding load and reports its status.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = reg_writeback_unit_pkg::DATA_WIDTH,
  parameter int NUM_REGISTER = reg_writeback_unit_pkg::NUM_REGISTER,
  parameter int LD_TIMEOUT   = 64
) (
  input logic                clk_i,
  input logic                rst_i,
  reg_writeback_unit_if.slave bus
);

  localparam int AW = $clog2(NUM_REGISTER);

  wb_state_e             r_state;
  logic                  r_ld_ready;
  logic                  r_load_busy;
  logic [AW-1:0]         r_ld_rd;
  logic [2:0]            r_ld_f3;
  logic [1:0]            r_ld_off;
  logic                  r_skid_vld;
  logic [AW-1:0]         r_skid_rd;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_we;
  logic [AW-1:0]         r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_err;

  logic                  w_ld_resp;
  logic                  w_alu_acc;
  logic                  w_timeout;
  logic                  w_fmt_ok;
  logic [DATA_WIDTH-1:0] w_fmt_data;
  logic                  w_fmt_mis;
  logic                  w_fmt_ill;

  load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .i_funct3     (r_ld_f3),
    .i_offset     (r_ld_off),
    .i_rdata      (bus.mem_rdata_i),
    .o_data       (w_fmt_data),
    .o_misaligned (w_fmt_mis),
    .o_illegal    (w_fmt_ill)
  );

  assign w_ld_resp = (r_state == LD_WAIT) & bus.mem_rvalid_i;
  assign w_alu_acc = bus.alu_valid_i & ~r_skid_vld;
  assign w_fmt_ok  = ~w_fmt_mis & ~w_fmt_ill;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int TO_W = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_state == LD_WAIT) & ~bus.mem_rvalid_i &
                     (r_to_cnt == TO_W'(LD_TIMEOUT - 1));

  // Count LD_WAIT cycles without a response; restarts on each new load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_to_cnt <= '0;
    end else if (!bus.mem_rvalid_i) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Outstanding-load FSM with registered ready/busy/destination outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ld_ready  <= 1'b1;
      r_load_busy <= 1'b0;
      r_ld_rd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ld_issue_i) begin
            r_state     <= LD_WAIT;
            r_ld_ready  <= 1'b0;
            r_load_busy <= 1'b1;
            r_ld_rd     <= bus.ld_rd_addr_i;
            r_ld_f3     <= bus.ld_funct3_i;
            r_ld_off    <= bus.ld_offset_i;
          end
        end
        LD_WAIT: begin
          if (bus.mem_rvalid_i || w_timeout) begin
            r_state     <= IDLE;
            r_ld_ready  <= 1'b1;
            r_load_busy <= 1'b0;
            r_ld_rd     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write-port arbitration: load response, then skid entry, then new ALU result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_rd_addr  <= '0;
      r_rd       <= '0;
      r_err      <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd      <= '0;
      r_err     <= (w_ld_resp & ~w_fmt_ok) | w_timeout;
      if (w_ld_resp) begin
        if (w_fmt_ok && (r_ld_rd != '0)) begin
          r_we      <= 1'b1;
          r_rd_addr <= r_ld_rd;
          r_rd      <= w_fmt_data;
        end
        if (w_alu_acc) begin
          r_skid_vld  <= 1'b1;
          r_skid_rd   <= bus.alu_rd_addr_i;
          r_skid_data <= bus.alu_data_i;
        end
      end else if (r_skid_vld) begin
        r_skid_vld <= 1'b0;
        if (r_skid_rd != '0) begin
          r_we      <= 1'b1;
          r_rd_addr <= r_skid_rd;
          r_rd      <= r_skid_data;
        end
      end else if (w_alu_acc && (bus.alu_rd_addr_i != '0)) begin
        r_we      <= 1'b1;
        r_rd_addr <= bus.alu_rd_addr_i;
        r_rd      <= bus.alu_data_i;
      end
    end
  end

  assign bus.alu_ready_o = ~r_skid_vld;
  assign bus.ld_ready_o  = r_ld_ready;
  assign bus.we_o        = r_we;
  assign bus.rd_addr_o   = r_rd_addr;
  assign bus.rd_o        = r_rd;
  assign bus.load_busy_o = r_load_busy;
  assign bus.load_rd_o   = r_ld_rd;
  assign bus.load_err_o  = r_err;

endmodule
